// File: rtl/v_mem_unit_pkg.sv
// rtl/v_mem_unit_pkg.sv - widths, beat counter sizing and FSM encoding for the vector load/store engine
package v_mem_unit_pkg;
  localparam int VLEN        = 512;
  localparam int BEAT_W      = 64;
  localparam int ADDR_W      = 64;
  localparam int VREG_ADDR_W = 5;
  localparam int BEATS       = VLEN / BEAT_W;
  localparam int CNT_W       = $clog2(BEATS + 1);
  localparam int IDX_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_LG     = $clog2(BEAT_W / 8);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } vmem_state_e;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + (ADDR_W'(idx) << BYTE_LG);
  endfunction
endpackage

// File: rtl/v_mem_beat_cnt.sv
// rtl/v_mem_beat_cnt.sv - issue/return beat counter pair with clear and last-beat flags
module v_mem_beat_cnt
  import v_mem_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             issue_inc,
  input  logic             ret_inc,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic             issue_last,
  output logic             ret_last,
  output logic             ret_full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (clr) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (issue_inc) issue_cnt <= issue_cnt + 1'b1;
      if (ret_inc)   ret_cnt   <= ret_cnt + 1'b1;
    end
  end

  assign issue_last = (issue_cnt == CNT_W'(BEATS - 1));
  assign ret_last   = (ret_cnt == CNT_W'(BEATS - 1));
  assign ret_full   = (ret_cnt == CNT_W'(BEATS));
endmodule

// File: rtl/v_mem_unit.sv
// rtl/v_mem_unit.sv - multi-beat vle32/vse32 engine; V_MEM_ALIGN_CHK_EN enables misalignment error
module v_mem_unit
  import v_mem_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vex_mem_req_i,
  input  logic                   vex_mem_we_i,
  input  logic [ADDR_W-1:0]      vex_mem_addr_i,
  input  logic [VLEN-1:0]        vex_mem_wdata_i,
  input  logic [VREG_ADDR_W-1:0] vex_mem_wb_addr_i,
  output logic                   vmem_busy_o,
  output logic                   vmem_done_o,
  output logic                   vmem_err_o,
  output logic                   vmem_wb_en_o,
  output logic [VREG_ADDR_W-1:0] vmem_wb_addr_o,
  output logic [VLEN-1:0]        vmem_result_o,
  output logic                   vram_req_o,
  output logic                   vram_we_o,
  output logic [ADDR_W-1:0]      vram_addr_o,
  output logic [BEAT_W-1:0]      vram_wdata_o,
  input  logic                   vram_gnt_i,
  input  logic                   vram_rvalid_i,
  input  logic [BEAT_W-1:0]      vram_rdata_i
);

  vmem_state_e state_q, state_d;

  logic                         we_q;
  logic                         err_q;
  logic [ADDR_W-1:0]            base_q;
  logic [BEATS-1:0][BEAT_W-1:0] wdata_q;
  logic [BEATS-1:0][BEAT_W-1:0] result_q;
  logic [VREG_ADDR_W-1:0]       wb_addr_q;

  logic             accept, misalign, issue_fire, ret_fire;
  logic [CNT_W-1:0] issue_cnt, ret_cnt;
  logic             issue_last, ret_last, ret_full;

  assign accept = (state_q == S_IDLE) && vex_mem_req_i;

`ifdef V_MEM_ALIGN_CHK_EN
  assign misalign = |vex_mem_addr_i[BYTE_LG-1:0];
`else
  assign misalign = 1'b0;
`endif

  assign issue_fire = (state_q == S_ISSUE) && vram_gnt_i;
  // Returns beyond the last beat, in IDLE/DONE, or during a store are dropped.
  assign ret_fire   = vram_rvalid_i && !we_q && !ret_full &&
                      ((state_q == S_ISSUE) || (state_q == S_DRAIN));

  v_mem_beat_cnt u_beat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept),
    .issue_inc  (issue_fire),
    .ret_inc    (ret_fire),
    .issue_cnt  (issue_cnt),
    .ret_cnt    (ret_cnt),
    .issue_last (issue_last),
    .ret_last   (ret_last),
    .ret_full   (ret_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    vram_req_o   = 1'b0;
    vram_we_o    = 1'b0;
    vram_addr_o  = '0;
    vram_wdata_o = '0;
    vmem_done_o  = 1'b0;
    vmem_busy_o  = (state_q != S_IDLE) || vex_mem_req_i;
    unique case (state_q)
      S_IDLE: begin
        if (vex_mem_req_i) state_d = misalign ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        vram_req_o   = 1'b1;
        vram_we_o    = we_q;
        vram_addr_o  = beat_addr(base_q, issue_cnt);
        vram_wdata_o = we_q ? wdata_q[issue_cnt[IDX_W-1:0]] : '0;
        if (issue_fire && issue_last) begin
          state_d = (we_q || ret_full) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ret_full || (ret_fire && ret_last)) state_d = S_DONE;
      end
      S_DONE: begin
        vmem_done_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
      wb_addr_q <= '0;
    end else begin
      if (accept) begin
        we_q      <= vex_mem_we_i;
        err_q     <= misalign;
        base_q    <= vex_mem_addr_i & ~ADDR_W'(BEAT_W / 8 - 1);
        wdata_q   <= vex_mem_wdata_i;
        wb_addr_q <= vex_mem_wb_addr_i;
      end
      if (ret_fire) result_q[ret_cnt[IDX_W-1:0]] <= vram_rdata_i;
    end
  end

`ifdef V_MEM_ALIGN_CHK_EN
  assign vmem_err_o = vmem_done_o && err_q;
`else
  assign vmem_err_o = 1'b0;
`endif

  assign vmem_wb_en_o   = vmem_done_o && !we_q && !err_q;
  assign vmem_wb_addr_o = wb_addr_q;
  assign vmem_result_o  = result_q;
endmodule

// File: tb/tb_v_mem_unit.sv
// tb/tb_v_mem_unit.sv - scoreboard bench for v_mem_unit with a random-stall RAM responder
module tb_v_mem_unit;
  import v_mem_unit_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   vex_mem_req_i = 1'b0;
  logic                   vex_mem_we_i = 1'b0;
  logic [ADDR_W-1:0]      vex_mem_addr_i = '0;
  logic [VLEN-1:0]        vex_mem_wdata_i = '0;
  logic [VREG_ADDR_W-1:0] vex_mem_wb_addr_i = '0;
  logic                   vmem_busy_o, vmem_done_o, vmem_err_o, vmem_wb_en_o;
  logic [VREG_ADDR_W-1:0] vmem_wb_addr_o;
  logic [VLEN-1:0]        vmem_result_o;
  logic                   vram_req_o, vram_we_o;
  logic [ADDR_W-1:0]      vram_addr_o;
  logic [BEAT_W-1:0]      vram_wdata_o;
  logic                   vram_gnt_i = 1'b0;
  logic                   vram_rvalid_i = 1'b0;
  logic [BEAT_W-1:0]      vram_rdata_i = '0;

  always #5 clk = ~clk;

  v_mem_unit dut (
    .clk(clk), .rst_n(rst_n),
    .vex_mem_req_i(vex_mem_req_i), .vex_mem_we_i(vex_mem_we_i),
    .vex_mem_addr_i(vex_mem_addr_i), .vex_mem_wdata_i(vex_mem_wdata_i),
    .vex_mem_wb_addr_i(vex_mem_wb_addr_i),
    .vmem_busy_o(vmem_busy_o), .vmem_done_o(vmem_done_o), .vmem_err_o(vmem_err_o),
    .vmem_wb_en_o(vmem_wb_en_o), .vmem_wb_addr_o(vmem_wb_addr_o),
    .vmem_result_o(vmem_result_o),
    .vram_req_o(vram_req_o), .vram_we_o(vram_we_o), .vram_addr_o(vram_addr_o),
    .vram_wdata_o(vram_wdata_o), .vram_gnt_i(vram_gnt_i),
    .vram_rvalid_i(vram_rvalid_i), .vram_rdata_i(vram_rdata_i)
  );

  typedef struct { logic [ADDR_W-1:0] addr; logic we; logic [BEAT_W-1:0] wdata; } beat_t;
  typedef struct {
    logic we; logic err; logic wb_en;
    logic [VREG_ADDR_W-1:0] wb_addr; logic [VLEN-1:0] result; int done_cyc;
  } cmpl_t;
  typedef struct { int due; logic [BEAT_W-1:0] data; } ret_t;

  beat_t exp_beat_q[$];
  cmpl_t exp_cmpl_q[$];
  ret_t  pend_q[$];
  logic [BEAT_W-1:0] ram[longint unsigned];
  logic [BEAT_W-1:0] mdl[longint unsigned];

  int cyc = 0, errors = 0, checks = 0, done_cnt = 0, n_exp = 0, rv_cnt = 0, last_due = 0;
  bit gnt_rand = 0;
  int lat_max = 1;
  logic [VLEN-1:0] last_result = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BEAT_W-1:0] dflt(input logic [ADDR_W-1:0] a);
    return {a[31:0] ^ 32'h5a5a_0000, ~a[31:0]};
  endfunction

  task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // RAM responder: grants, in-order read returns with 1..lat_max cycles latency.
  initial begin
    ret_t r;
    int due;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge clk);
      vram_rvalid_i = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        r = pend_q.pop_front();
        vram_rvalid_i = 1'b1;
        vram_rdata_i  = r.data;
        rv_cnt++;
      end
      vram_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst_n && vram_req_o && vram_gnt_i) begin
        a = vram_addr_o;
        if (vram_we_o) ram[a] = vram_wdata_o;
        else begin
          due = cyc + int'($urandom_range(1, lat_max));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          r.due  = due;
          r.data = ram.exists(a) ? ram[a] : dflt(a);
          pend_q.push_back(r);
        end
      end
    end
  end

  // Monitor: compares every granted beat and every completion against the scoreboard.
  initial begin
    beat_t b;
    cmpl_t c;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (vram_req_o && vram_gnt_i) begin
          if (exp_beat_q.size() == 0) fail("unexpected_vram_req");
          else begin
            b = exp_beat_q.pop_front();
            check("beat_addr", VLEN'(vram_addr_o), VLEN'(b.addr));
            check("beat_we", VLEN'(vram_we_o), VLEN'(b.we));
            if (b.we) check("beat_wdata", VLEN'(vram_wdata_o), VLEN'(b.wdata));
          end
        end
        if (exp_cmpl_q.size() > 0) check("busy", VLEN'(vmem_busy_o), VLEN'(1'b1));
        if (vmem_done_o) begin
          if (exp_cmpl_q.size() == 0) fail("unexpected_done");
          else begin
            c = exp_cmpl_q.pop_front();
            check("done_err", VLEN'(vmem_err_o), VLEN'(c.err));
            check("done_wb_en", VLEN'(vmem_wb_en_o), VLEN'(c.wb_en));
            check("done_wb_addr", VLEN'(vmem_wb_addr_o), VLEN'(c.wb_addr));
            check("done_result", vmem_result_o, c.result);
            if (!c.we && !c.err) check("returns_before_done", VLEN'(rv_cnt), VLEN'(BEATS));
            if (c.done_cyc >= 0) check("done_cycle", VLEN'(cyc), VLEN'(c.done_cyc));
            if (exp_beat_q.size() != 0) fail("done_with_beats_outstanding");
          end
          done_cnt++;
        end
      end
    end
  end

  task automatic push_expect(input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [VLEN-1:0] wd, input logic [VREG_ADDR_W-1:0] vd,
                             input int acc);
    cmpl_t c;
    beat_t b;
    logic [ADDR_W-1:0] ab, a;
    logic [VLEN-1:0] r;
    bit chk, fixed;
`ifdef V_MEM_ALIGN_CHK_EN
    chk = 1;
`else
    chk = 0;
`endif
    fixed = !gnt_rand && (lat_max == 1);
    ab = {addr[ADDR_W-1:3], 3'b000};
    c.we = we; c.wb_addr = vd; c.err = 0; c.wb_en = 0; c.result = last_result; c.done_cyc = -1;
    if (chk && addr[2:0] != 3'b000) begin
      c.err = 1;
      c.done_cyc = acc + 1;
    end else if (we) begin
      for (int k = 0; k < BEATS; k++) begin
        b.addr = ab + ADDR_W'(8 * k); b.we = 1'b1; b.wdata = wd[k*BEAT_W +: BEAT_W];
        exp_beat_q.push_back(b);
        mdl[b.addr] = b.wdata;
      end
      if (fixed) c.done_cyc = acc + BEATS + 1;
    end else begin
      for (int k = 0; k < BEATS; k++) begin
        a = ab + ADDR_W'(8 * k);
        b.addr = a; b.we = 1'b0; b.wdata = '0;
        exp_beat_q.push_back(b);
        r[k*BEAT_W +: BEAT_W] = mdl.exists(a) ? mdl[a] : dflt(a);
      end
      last_result = r;
      c.result = r;
      c.wb_en = 1;
      if (fixed) c.done_cyc = acc + BEATS + 2;
    end
    exp_cmpl_q.push_back(c);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (done_cnt < target) begin
      fail("done_timeout");
      exp_beat_q.delete();
      exp_cmpl_q.delete();
      done_cnt = target;
    end
  endtask

  task automatic do_op(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [VLEN-1:0] wd, input logic [VREG_ADDR_W-1:0] vd);
    push_expect(we, addr, wd, vd, cyc);
    vex_mem_req_i = 1'b1; vex_mem_we_i = we; vex_mem_addr_i = addr;
    vex_mem_wdata_i = wd; vex_mem_wb_addr_i = vd;
    rv_cnt = 0;
    @(posedge clk);
    #1;
    vex_mem_req_i = 1'b0;
    n_exp++;
    wait_done(n_exp);
  endtask

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int k = 0; k < VLEN / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [VLEN-1:0] wd, res1;
    int a1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", VLEN'(vmem_busy_o), '0);
    check("rst_done", VLEN'(vmem_done_o), '0);
    check("rst_err", VLEN'(vmem_err_o), '0);
    check("rst_wb_en", VLEN'(vmem_wb_en_o), '0);
    check("rst_wb_addr", VLEN'(vmem_wb_addr_o), '0);
    check("rst_result", vmem_result_o, '0);
    check("rst_vram_req", VLEN'(vram_req_o), '0);
    check("rst_vram_addr", VLEN'(vram_addr_o), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < BEATS; k++) begin
      ram[64'h1000 + 8 * k] = BEAT_W'(k);
      mdl[64'h1000 + 8 * k] = BEAT_W'(k);
    end
    do_op(1'b0, 64'h1000, '0, 5'd5);
    for (int k = 0; k < BEATS; k++) wd[k*BEAT_W +: BEAT_W] = BEAT_W'(32'hA0 + k);
    do_op(1'b1, 64'h2000, wd, 5'd7);
    do_op(1'b0, 64'h2000, '0, 5'd8);

    gnt_rand = 1; lat_max = 4;
    do_op(1'b0, 64'h1000, '0, 5'd6);
    for (int i = 0; i < 24; i++)
      do_op(1'($urandom_range(0, 2) == 0), 64'h1000 + 64'(8 * $urandom_range(0, 47)),
            rand_vec(), 5'($urandom_range(0, 31)));
    gnt_rand = 0; lat_max = 1;

    do_op(1'b0, 64'h1004, '0, 5'd4);

    // Reset while beat 3 of a load is on the bus.
    a1 = cyc;
    push_expect(1'b0, 64'h1000, '0, 5'd2, a1);
    vex_mem_req_i = 1'b1; vex_mem_we_i = 1'b0; vex_mem_addr_i = 64'h1000; vex_mem_wb_addr_i = 5'd2;
    @(posedge clk);
    #1;
    vex_mem_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_vram_req", VLEN'(vram_req_o), '0);
    check("midrst_busy", VLEN'(vmem_busy_o), '0);
    check("midrst_result", vmem_result_o, '0);
    check("midrst_wb_addr", VLEN'(vmem_wb_addr_o), '0);
    check("midrst_done", VLEN'(vmem_done_o), '0);
    exp_beat_q.delete();
    exp_cmpl_q.delete();
    last_result = '0;
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("stale_rvalid_ignored", vmem_result_o, '0);
    do_op(1'b0, 64'h1000, '0, 5'd11);

    // Back-to-back loads with req held high.
    a1 = cyc;
    push_expect(1'b0, 64'h1100, '0, 5'd3, a1);
    res1 = last_result;
    vex_mem_req_i = 1'b1; vex_mem_we_i = 1'b0; vex_mem_addr_i = 64'h1100; vex_mem_wb_addr_i = 5'd3;
    rv_cnt = 0;
    @(posedge clk);
    #1;
    vex_mem_addr_i = 64'h1200; vex_mem_wb_addr_i = 5'd9;
    repeat (10) @(posedge clk);
    #1;
    push_expect(1'b0, 64'h1200, '0, 5'd9, a1 + 11);
    rv_cnt = 0;
    @(posedge clk);
    #1;
    vex_mem_req_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    check("b2b_result_held", vmem_result_o, res1);
    n_exp += 2;
    wait_done(n_exp);
    repeat (3) @(posedge clk);
    #1;
    if (exp_cmpl_q.size() != 0 || exp_beat_q.size() != 0) fail("scoreboard_not_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/v_mem_unit.md
# v_mem_unit

Multi-beat vector load/store engine for `vle32.v` / `vse32.v`. Splits one VLEN-bit vector access into BEAT_W-bit data-RAM beats using a req/gnt issue handshake and in-order rvalid returns. Reassembles load data into the VLEN-bit result that feeds the write-back mux's memory input. Raises busy so the vector pipeline stalls for the duration.

## Interface
- VLEN, 512: vector register width (bits); equals `VREG_BUS` width
- BEAT_W, 64: data-RAM bus width; VLEN % BEAT_W == 0; BEATS = VLEN/BEAT_W
- ADDR_W, 64: byte address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- vex_mem_req_i  in  1  access request, sampled in IDLE only
- vex_mem_we_i  in  1  1 = store (vse32), 0 = load (vle32)
- vex_mem_addr_i  in  ADDR_W  base byte address
- vex_mem_wdata_i  in  VLEN  store data (vs3), captured at accept
- vex_mem_wb_addr_i  in  `VREG_ADDR_BUS`  load destination vd, captured at accept
- vmem_busy_o  out  1  stall to upstream
- vmem_done_o  out  1  one-cycle completion pulse
- vmem_err_o  out  1  one-cycle misalignment pulse (see Configuration)
- vmem_wb_en_o  out  1  load write-back enable, equals done & ~we & ~err
- vmem_wb_addr_o  out  `VREG_ADDR_BUS`  captured vd
- vmem_result_o  out  VLEN  assembled load data
- vram_req_o, vram_we_o  out  1  beat request / write strobe
- vram_addr_o  out  ADDR_W  beat address
- vram_wdata_o  out  BEAT_W  beat store data
- vram_gnt_i  in  1  beat accepted this cycle when req & gnt
- vram_rvalid_i  in  1  read beat returning
- vram_rdata_i  in  BEAT_W  read beat data

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: req → capture addr (low log2(BEAT_W/8) bits forced 0), wdata, wb_addr, we; clear issue_cnt and ret_cnt; go to ISSUE.
- ISSUE: vram_req_o = 1, addr = base + issue_cnt·(BEAT_W/8), wdata = wdata_q[issue_cnt·BEAT_W +: BEAT_W]. Each req&gnt increments issue_cnt.
- After the gnt of beat BEATS-1: a store goes to DONE; a load goes to DRAIN, or straight to DONE if ret_cnt already equals BEATS.
- Loads: each rvalid, in ISSUE or DRAIN, writes rdata into result[ret_cnt·BEAT_W +: BEAT_W] and increments ret_cnt. DRAIN → DONE when ret_cnt reaches BEATS, counting the current beat.
- DONE: done=1 for one cycle, wb_en per Interface, then IDLE.
- vmem_busy_o = (state != IDLE) | vex_mem_req_i (combinational).
- rvalid in IDLE/DONE, or for a store, is ignored. Requests outside IDLE are ignored; upstream holds on busy.
- vmem_result_o keeps its value until the next load's first rvalid.

## Timing
- Reset values: state IDLE, all outputs 0, result 0, counters 0.
- rvalid for beat k arrives ≥1 cycle after its gnt. rvalid and gnt may both occur in the same cycle for different beats.
- Minimum latency with gnt always 1 and rvalid latency 1, counting from the accept cycle:
  - store: done at accept+BEATS+1
  - load: done at accept+BEATS+2
- Reset mid-operation returns to IDLE immediately. No done pulse; result cleared.

## Configuration
- V_MEM_ALIGN_CHK_EN defined:
  - In IDLE, a req with addr[log2(BEAT_W/8)-1:0] != 0 goes directly to DONE.
  - No vram traffic; err=1 and done=1 in that cycle; wb_en=0.
- Undefined: low bits silently forced 0; vmem_err_o tied 0.

## Structure
- v_defines.v holds: VLEN, BEAT_W, BEATS and its counter width, and the FSM state encodings (2-bit).
- One sub-module: v_mem_beat_cnt. It holds the issue/return counter pair, with inc inputs, clear, and issue_last/ret_last flags.

## Test plan
- Load, base 0x1000, gnt=1, rvalid 1 cycle later, beats 0x0..0x7 → addrs 0x1000..0x1038; result beat k = k; done at cycle 10 with wb_en=1 and wb_addr=captured vd.
- Store, base 0x2000, wdata beat k = 0xA0+k, gnt=1 → 8 writes with correct data; done at cycle 9; wb_en=0.
- Load with gnt random 50% and rvalid latency 1–4 → result identical to the no-stall case; busy high throughout; no done before beat 8 returns.
- Load with base 0x1004:
  - with V_MEM_ALIGN_CHK_EN: no vram_req; err=done=1 next cycle.
  - without: accesses start at 0x1000.
- rst_n low during beat 3 of a load → outputs 0 asynchronously. After release, a new load completes normally and stale rvalid is ignored.
- Back-to-back load requests, req held high → second accepted the cycle after DONE; first result unchanged until second's first rvalid.
